// File: rtl/adder_sum_sequencer_pkg.sv
// Shared types and constants for the burst-sum sequencer.
// The state encoding doubles as the debug encoding exposed on dbg_state.
package adder_sum_sequencer_pkg;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/eightBitAdder.sv
// Plain 8-bit unsigned adder with carry-out and no carry-in.
module eightBitAdder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/adder_sum_sequencer.sv
// Accumulates N_SAMPLES 8-bit samples into a 16-bit sum using one shared
// 8-bit adder: low byte pass, then high byte plus the captured carry.
module adder_sum_sequencer
  import adder_sum_sequencer_pkg::*;
#(
  parameter int N_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here come from registered state only.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  state_t           state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sample_r;
  logic             carry_r;
  logic [7:0]       add_a, add_b, add_sum;
  logic             add_cout;

  eightBitAdder u_adder (
    .A    (add_a),
    .B    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_next = state;
    add_a      = 8'd0;
    add_b      = 8'd0;
    unique case (state)
      IDLE: begin
        if (in_valid) state_next = ADD_LO;
      end
      ADD_LO: begin
        add_a      = acc[7:0];
        add_b      = sample_r;
        state_next = ADD_HI;
      end
      ADD_HI: begin
        add_a      = acc[15:8];
        add_b      = {7'b0, carry_r};
        state_next = (cnt == LAST_CNT) ? DONE : IDLE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      sample_r <= '0;
      carry_r  <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        acc     <= '0;
        cnt     <= '0;
        carry_r <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid) sample_r <= in_data;
          end
          ADD_LO: begin
            acc[7:0] <= add_sum;
            carry_r  <= add_cout;
          end
          ADD_HI: begin
            // cout is structurally zero here: 255 * 255 fits in 16 bits.
            acc[15:8] <= add_sum;
            cnt       <= cnt + 1'b1;
          end
          DONE: begin
            if (out_ready) begin
              acc <= '0;
              cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum_out   = acc;
  assign dbg_state = state;

endmodule

// File: tb/tb_adder_sum_sequencer.sv
// Randomized bench for adder_sum_sequencer: a N=4 instance and a N=255
// instance, checked against a plain arithmetic sum of the offered samples.
module tb_adder_sum_sequencer;
  import adder_sum_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clear     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] sum_out   [2];
  logic        busy      [2];
  state_t      dbg_state [2];

  int total = 0;
  int bad   = 0;
  logic [7:0]  stim_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

  adder_sum_sequencer #(.N_SAMPLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum_out(sum_out[0]), .busy(busy[0]),
    .dbg_state(dbg_state[0])
  );

  adder_sum_sequencer #(.N_SAMPLES(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum_out(sum_out[1]), .busy(busy[1]),
    .dbg_state(dbg_state[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: wait (bounded) for in_ready, then transfer one sample
  task automatic send_one(input int d, input logic [7:0] data);
    int w = 0;
    while (in_ready[d] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (in_ready[d] !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout dut%0d got=%b want=1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // driver: send the whole of stim_q as one burst, check latency and sum
  task automatic run_burst(input int d);
    int s = 0;
    foreach (stim_q[i]) s += int'(stim_q[i]);
    exp_q.push_back(16'(s));
    while (stim_q.size() > 0) send_one(d, stim_q.pop_front());
    total++;
    if (out_valid[d] !== 1'b0) begin
      bad++; $display("FAIL lat_cycle1 dut%0d got=%b want=0", d, out_valid[d]);
    end
    @(negedge clk);
    total++;
    if (out_valid[d] !== 1'b0) begin
      bad++; $display("FAIL lat_cycle2 dut%0d got=%b want=0", d, out_valid[d]);
    end
    @(negedge clk);
    total++;
    if (out_valid[d] !== 1'b1) begin
      bad++; $display("FAIL lat_cycle3 dut%0d got=%b want=1", d, out_valid[d]);
    end
    last_exp = exp_q.pop_front();
    total++;
    if (sum_out[d] !== last_exp) begin
      bad++; $display("FAIL burst_sum dut%0d got=%h want=%h", d, sum_out[d], last_exp);
    end
    if (out_ready[d] === 1'b1) begin
      @(negedge clk);
      total++;
      if (in_ready[d] !== 1'b1 || sum_out[d] !== 16'h0 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
        bad++;
        $display("FAIL post_handshake dut%0d got rdy=%b sum=%h ov=%b busy=%b want 1/0000/0/0",
                 d, in_ready[d], sum_out[d], out_valid[d], busy[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || sum_out[d] !== 16'h0 || busy[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got rdy=%b ov=%b sum=%h busy=%b want 1/0/0000/0",
                 d, in_ready[d], out_valid[d], sum_out[d], busy[d]);
      end
    end
  endtask

  task automatic test_basic();
    stim_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_burst(0);
    total++;
    if (last_exp !== 16'h00A0) begin
      bad++; $display("FAIL basic_model got=%h want=00a0", last_exp);
    end
  endtask

  task automatic test_carry();
    stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_burst(0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom_range(0, 255)));
      run_burst(0);
    end
  endtask

  task automatic test_max_burst();
    for (int i = 0; i < 255; i++) stim_q.push_back(8'hFF);
    run_burst(1);
    total++;
    if (last_exp !== 16'hFE01) begin
      bad++; $display("FAIL max_model got=%h want=fe01", last_exp);
    end
  endtask

  task automatic test_backpressure();
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    run_burst(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (out_valid[0] !== 1'b1 || sum_out[0] !== last_exp || busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d got ov=%b sum=%h busy=%b rdy=%b want 1/%h/1/0",
                 c, out_valid[0], sum_out[0], busy[0], in_ready[0], last_exp);
      end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready[0] !== 1'b1 || sum_out[0] !== 16'h0 || dbg_state[0] !== IDLE) begin
      bad++;
      $display("FAIL backpressure_release got rdy=%b sum=%h st=%0d want 1/0000/0",
               in_ready[0], sum_out[0], dbg_state[0]);
    end
  endtask

  task automatic test_clear();
    send_one(0, 8'h11);
    send_one(0, 8'h22);
    @(negedge clk);
    total++;
    if (dbg_state[0] !== ADD_HI) begin
      bad++; $display("FAIL clear_setup got st=%0d want=%0d", dbg_state[0], ADD_HI);
    end
    clear[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    @(negedge clk);
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    total++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || sum_out[0] !== 16'h0 || dbg_state[0] !== IDLE) begin
      bad++;
      $display("FAIL clear_abort got rdy=%b busy=%b sum=%h st=%0d want 1/0/0000/0",
               in_ready[0], busy[0], sum_out[0], dbg_state[0]);
    end
    stim_q = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_burst(0);
  endtask

  task automatic test_async_reset();
    send_one(0, 8'h05);
    total++;
    if (dbg_state[0] !== ADD_LO) begin
      bad++; $display("FAIL areset_setup got st=%0d want=%0d", dbg_state[0], ADD_LO);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || sum_out[0] !== 16'h0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate got rdy=%b ov=%b sum=%h busy=%b want 1/0/0000/0",
               in_ready[0], out_valid[0], sum_out[0], busy[0]);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    run_burst(0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 1'b1;
    end
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_max_burst();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_sum_sequencer.md
# adder_sum_sequencer

Time-multiplexes one `eightBitAdder` instance to accumulate a burst of N_SAMPLES unsigned 8-bit sensor readings into a 16-bit total. Each sample costs two adder passes: low byte first, then high byte plus the captured carry. The block sits between a sensor-sample producer (valid/ready) and a downstream consumer of the burst sum, such as averaging or alarm logic. One adder instance is shared across both passes, so no 16-bit adder is built.

## Interface
Parameters:
- N_SAMPLES, default 8: samples per burst; legal range 1..255.

Ports:
- clk, input, 1: the only clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous abort; drops the current burst.
- in_valid, input, 1: `in_data` is valid.
- in_ready, output, 1: the block accepts a sample this cycle.
- in_data, input, 8: unsigned sample.
- out_valid, output, 1: `sum_out` holds a completed burst sum.
- out_ready, input, 1: the consumer accepts `sum_out`.
- sum_out, output, 16: burst sum; equals the accumulator.
- busy, output, 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: in_ready=1. On `in_valid` & `in_ready`: sample_r<=in_data; go to ADD_LO.
  - ADD_LO: adder A=acc[7:0], B=sample_r. Write acc[7:0]<=sum and carry_r<=cout. Go to ADD_HI.
  - ADD_HI: adder A=acc[15:8], B={7'b0,carry_r}. Write acc[15:8]<=sum and cnt<=cnt+1.
    - If cnt==N_SAMPLES-1 (pre-increment value): go to DONE.
    - Otherwise: go to IDLE.
  - DONE: out_valid=1 and `sum_out` is stable. On out_ready: acc<=0, cnt<=0, go to IDLE.
- Adder inputs are driven by a state-selected mux. Values in other states are don't-care, but are driven to zero.
- Adder cout in ADD_HI is ignored. It is always 0 because max sum 255×255=65025 < 2^16, so no overflow flag exists.
- `clear` high at any edge: acc<=0, cnt<=0, carry_r<=0, go to IDLE.
  - Takes priority over every transition, including a same-cycle input or output handshake.
  - A sample offered in that cycle is not consumed.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- `in_ready` is 0 whenever state≠IDLE. Producers must hold `in_data` stable while in_valid=1 and in_ready=0.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, sample_r=0, carry_r=0.
- Outputs at reset: in_ready=1, out_valid=0, sum_out=0, busy=0.
- Per-sample occupancy is 3 cycles (IDLE accept, ADD_LO, ADD_HI). Maximum input rate is 1 sample per 3 clocks.
- Latency: the last sample is accepted at edge E0. ADD_LO runs at E1 and ADD_HI at E2. out_valid is high from the cycle after E2 until the out_ready handshake.
- DONE holds indefinitely under out_ready=0 (backpressure). in_ready stays 0 throughout.
- After the out handshake edge: in_ready=1 in the next cycle, and sum_out reads 0.
- N_SAMPLES=1: the IDLE→ADD_LO→ADD_HI→DONE path is taken on every sample.
- rst_n low mid-burst (any state): immediate async return to reset values. The partial sum is lost.

## Structure
- Shared header: state encoding localparams IDLE=2'd0, ADD_LO=2'd1, ADD_HI=2'd2, DONE=2'd3, and the accumulator width constant 16.
- Exactly one sub-module: the existing `eightBitAdder` (A, B, sum, cout; no carry-in), instantiated once.
- Counter width: 8 bits, sufficient for N_SAMPLES≤255.

## Test plan
- Basic sum: N=4, samples 0x10,0x20,0x30,0x40, out_ready=1.
  - sum_out=0x00A0.
  - out_valid rises 3 cycles after the 4th accept.
- Carry chain: N=4, four samples of 0xFF → sum_out=0x03FC, with carry into the high byte on samples 2–4.
- Max burst: N=255, all samples 0xFF → sum_out=0xFE01, no wrap.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid, sum_out and busy stay stable.
  - in_ready=0 throughout.
  - Raising out_ready → IDLE next cycle with acc=0.
- Abort: `clear` asserted in ADD_HI of sample 2, with in_valid=1 in the same cycle.
  - IDLE next cycle, acc=0, cnt=0.
  - A new burst of 0x01×4 yields 0x0004.
- Async reset: rst_n pulsed low mid-ADD_LO and released off-edge → all outputs at reset values immediately, no extra sample counted.
